// File: rtl/rc_channel_scheduler_pkg.sv
// Shared types and constants for the RC channel scheduler: FSM state encoding
// and the width of the per-channel glitch counters.
package rc_sched_pkg;

  typedef enum logic [1:0] {
    RCS_IDLE  = 2'd0,
    RCS_CHECK = 2'd1,
    RCS_EMIT  = 2'd2
  } rcs_state_t;

  localparam int GLITCH_W = 8;

endpackage

// File: rtl/rc_channel_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// scanning upward from ptr with wrap-around.
module rr_arbiter #(
  parameter  int N  = 6,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  always_comb begin
    int idx;
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/rc_channel_scheduler.sv
// Round-robin scheduler for RC pulse-capture channels with pulse-window check,
// per-channel loss timeout and failsafe. Optional glitch counters: RC_SCHED_GLITCH_CNT_EN.
module rc_channel_scheduler
  import rc_sched_pkg::*;
#(
  parameter  int NUM_CH        = 6,
  parameter  int COUNTER_WIDTH = 32,
  parameter  int MIN_WIDTH_CYC = 90000,
  parameter  int MAX_WIDTH_CYC = 210000,
  parameter  int TIMEOUT_CYC   = 2500000,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int TO_W          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_CH-1:0][COUNTER_WIDTH-1:0]   ch_width,
  input  logic [NUM_CH-1:0]                      ch_new_data,
  input  logic [NUM_CH-1:0]                      ch_overflow,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [CH_W-1:0]                        out_ch,
  output logic [COUNTER_WIDTH-1:0]               out_width,
  output logic [NUM_CH-1:0]                      ch_lost,
  output logic                                   failsafe,
  output logic [NUM_CH-1:0][GLITCH_W-1:0]        glitch_cnt
);

  localparam logic [COUNTER_WIDTH-1:0] MIN_W  = COUNTER_WIDTH'(MIN_WIDTH_CYC);
  localparam logic [COUNTER_WIDTH-1:0] MAX_W  = COUNTER_WIDTH'(MAX_WIDTH_CYC);
  localparam logic [TO_W-1:0]          TO_MAX = TO_W'(TIMEOUT_CYC);

  rcs_state_t               state_reg, state_next;
  logic [CH_W-1:0]          rr_ptr_reg;
  logic [COUNTER_WIDTH-1:0] work_w_reg;
  logic [CH_W-1:0]          work_ch_reg;
  logic                     out_valid_reg;
  logic [CH_W-1:0]          out_ch_reg;
  logic [COUNTER_WIDTH-1:0] out_width_reg;
  logic                     failsafe_reg;

  logic [NUM_CH-1:0]        pend_vec;
  logic [NUM_CH-1:0]        lost_vec;
  logic [COUNTER_WIDTH-1:0] buf_arr [NUM_CH];

  logic [CH_W-1:0]          arb_grant;
  logic                     arb_any;
  logic                     grant_take;
  logic                     in_window;
  logic                     accept_legal;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req     (pend_vec),
    .ptr     (rr_ptr_reg),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  assign grant_take   = (state_reg == RCS_IDLE) && arb_any;
  assign in_window    = (work_w_reg >= MIN_W) && (work_w_reg <= MAX_W);
  assign accept_legal = (state_reg == RCS_CHECK) && in_window;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RCS_IDLE:  if (arb_any) state_next = RCS_CHECK;
      RCS_CHECK: state_next = in_window ? RCS_EMIT : RCS_IDLE;
      RCS_EMIT:  if (out_ready) state_next = RCS_IDLE;
      default:   state_next = RCS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RCS_IDLE;
      rr_ptr_reg    <= '0;
      work_w_reg    <= '0;
      work_ch_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      out_width_reg <= '0;
      failsafe_reg  <= 1'b1;
    end else begin
      state_reg    <= state_next;
      failsafe_reg <= |lost_vec;
      if (grant_take) begin
        // The grant always takes the buffered value, never a same-cycle strobe.
        work_w_reg  <= buf_arr[arb_grant];
        work_ch_reg <= arb_grant;
        rr_ptr_reg  <= (arb_grant == CH_W'(NUM_CH - 1)) ? '0 : arb_grant + CH_W'(1);
      end
      if (accept_legal) begin
        out_valid_reg <= 1'b1;
        out_ch_reg    <= work_ch_reg;
        out_width_reg <= work_w_reg;
      end else if ((state_reg == RCS_EMIT) && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic                     pend_reg;
    logic                     lost_reg;
    logic [COUNTER_WIDTH-1:0] buf_reg;
    logic [TO_W-1:0]          to_cnt_reg;
    logic                     take;
    logic                     clr;

    assign take = grant_take && (arb_grant == CH_W'(gi));
    assign clr  = accept_legal && (work_ch_reg == CH_W'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend_reg   <= 1'b0;
        buf_reg    <= '0;
        to_cnt_reg <= '0;
        lost_reg   <= 1'b1;
      end else begin
        if (ch_new_data[gi]) begin
          buf_reg  <= ch_width[gi];
          pend_reg <= 1'b1;
        end else if (take) begin
          pend_reg <= 1'b0;
        end
        if (clr)                       to_cnt_reg <= '0;
        else if (to_cnt_reg != TO_MAX) to_cnt_reg <= to_cnt_reg + TO_W'(1);
        // Overflow beats a same-cycle clear from a legal pulse.
        if (ch_overflow[gi])            lost_reg <= 1'b1;
        else if (clr)                   lost_reg <= 1'b0;
        else if (to_cnt_reg == TO_MAX)  lost_reg <= 1'b1;
      end
    end

    assign pend_vec[gi] = pend_reg;
    assign lost_vec[gi] = lost_reg;
    assign buf_arr[gi]  = buf_reg;

`ifdef RC_SCHED_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_reg;
    logic                reject_hit;
    assign reject_hit = (state_reg == RCS_CHECK) && !in_window && (work_ch_reg == CH_W'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  glitch_reg <= '0;
      else if (reject_hit && (glitch_reg != '1))   glitch_reg <= glitch_reg + GLITCH_W'(1);
    end
    assign glitch_cnt[gi] = glitch_reg;
`else
    assign glitch_cnt[gi] = '0;
`endif
  end

  assign out_valid = out_valid_reg;
  assign out_ch    = out_ch_reg;
  assign out_width = out_width_reg;
  assign ch_lost   = lost_vec;
  assign failsafe  = failsafe_reg;

endmodule

// File: tb/tb_rc_channel_scheduler.sv
// Directed bench for rc_channel_scheduler: latency, window bounds, round-robin,
// backpressure/overwrite, timeout/overflow and reset during EMIT.
module tb_rc_channel_scheduler;

  localparam int NCH = 6;
  localparam int CW  = 32;
  localparam int TO  = 200;
`ifdef RC_SCHED_GLITCH_CNT_EN
  localparam int GLITCH_STEP = 1;
`else
  localparam int GLITCH_STEP = 0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NCH-1:0][CW-1:0] ch_width;
  logic [NCH-1:0]         ch_new_data;
  logic [NCH-1:0]         ch_overflow;
  logic                   out_valid;
  logic                   out_ready;
  logic [2:0]             out_ch;
  logic [CW-1:0]          out_width;
  logic [NCH-1:0]         ch_lost;
  logic                   failsafe;
  logic [NCH-1:0][7:0]    glitch_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  rc_channel_scheduler #(
    .NUM_CH        (NCH),
    .COUNTER_WIDTH (CW),
    .MIN_WIDTH_CYC (90000),
    .MAX_WIDTH_CYC (210000),
    .TIMEOUT_CYC   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_width    (ch_width),
    .ch_new_data (ch_new_data),
    .ch_overflow (ch_overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_width   (out_width),
    .ch_lost     (ch_lost),
    .failsafe    (failsafe),
    .glitch_cnt  (glitch_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [NCH-1:0] mask, input int base, input int step);
    for (int k = 0; k < NCH; k++) ch_width[k] = CW'(base + k * step);
    ch_new_data = mask;
    tick();
    ch_new_data = '0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    if (!out_valid) chk("valid_timeout", out_valid, 1);
    else $display("emit ch=%0d width=%0d", out_ch, out_width);
  endtask

  task automatic expect_emit(input int ch, input int w);
    wait_valid(8);
    chk("emit_ch", out_ch, ch);
    chk("emit_width", out_width, w);
    tick();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    ch_new_data = '0;
    ch_overflow = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    ch_width    = '0;
    ch_new_data = '0;
    ch_overflow = '0;
    out_ready   = 1'b1;
    rst_n       = 1'b0;
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_width", out_width, 0);
    chk("rst_lost", ch_lost, 6'h3F);
    chk("rst_failsafe", failsafe, 1);
    chk("rst_glitch", glitch_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Single pulse: exact three-edge latency.
    strobe(6'b000100, 150000, 0);
    chk("lat_pend", out_valid, 0);
    tick();
    chk("lat_check", out_valid, 0);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_ch", out_ch, 2);
    chk("lat_width", out_width, 150000);
    chk("lat_lost_clr", ch_lost, 6'h3B);
    $display("emit ch=%0d width=%0d", out_ch, out_width);
    tick();
    chk("lat_accepted", out_valid, 0);

    // Window bounds.
    strobe(6'b000010, 89999, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("low_reject", out_valid, 0);
    end
    chk("glitch_low", glitch_cnt[1], GLITCH_STEP);
    strobe(6'b000010, 210001, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("high_reject", out_valid, 0);
    end
    chk("glitch_high", glitch_cnt[1], 2 * GLITCH_STEP);
    chk("glitch_other", glitch_cnt[0], 0);
    strobe(6'b000010, 90000, 0);
    expect_emit(1, 90000);
    strobe(6'b000010, 210000, 0);
    expect_emit(1, 210000);

    // Round-robin from a fresh pointer, then a wrap from pointer 4.
    do_reset();
    strobe(6'b101001, 100000, 1000);
    expect_emit(0, 100000);
    expect_emit(3, 103000);
    expect_emit(5, 105000);
    strobe(6'b001000, 120000, 0);
    expect_emit(3, 120000);
    strobe(6'b100001, 100000, 1000);
    expect_emit(5, 105000);
    expect_emit(0, 100000);

    // Backpressure with overwrite of the pending channel-1 sample.
    out_ready = 1'b0;
    strobe(6'b000010, 110000, 0);
    wait_valid(8);
    chk("bp_ch", out_ch, 1);
    chk("bp_width", out_width, 110000);
    strobe(6'b000010, 120000, 0);
    tick();
    strobe(6'b000010, 130000, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_width", out_width, 110000);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release", out_valid, 0);
    expect_emit(1, 130000);

    // Timeout on channel 4 while the others are refreshed.
    do_reset();
    strobe(6'h3F, 100000, 1000);
    for (int n = 0; n < 40 && !(out_valid && out_ch == 3'd4); n++) tick();
    chk("to_ch4_emit", {out_valid, out_ch}, {1'b1, 3'd4});
    chk("to_lost4_clr", ch_lost[4], 0);
    for (int i = 1; i <= TO + 2; i++) begin
      if (i == 30) ch_new_data = 6'b101111;
      tick();
      ch_new_data = '0;
      if (i == 29) chk("fs_clear", failsafe, 0);
      if (i == TO) chk("lost4_hold", ch_lost[4], 0);
      if (i == TO + 1) begin
        chk("lost4_set", ch_lost[4], 1);
        chk("fs_lag", failsafe, 0);
      end
      if (i == TO + 2) chk("fs_set", failsafe, 1);
    end

    // Overflow overrides a legal-pulse clear.
    ch_overflow = 6'b000001;
    strobe(6'b000001, 150000, 0);
    wait_valid(8);
    chk("ovf_ch", out_ch, 0);
    chk("ovf_lost", ch_lost[0], 1);
    tick();
    ch_overflow = '0;
    tick();
    chk("ovf_sticky", ch_lost[0], 1);

    // Reset during EMIT with another sample pending.
    out_ready = 1'b0;
    strobe(6'b000100, 150000, 0);
    wait_valid(8);
    strobe(6'b001000, 160000, 0);
    chk("mid_valid_pre", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid_drop", out_valid, 0);
    chk("mid_lost", ch_lost, 6'h3F);
    chk("mid_failsafe", failsafe, 1);
    chk("mid_width", out_width, 0);
    repeat (2) tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mid_no_stale", out_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
